// File: rtl/beep_driver.sv
// Piezo buzzer driver: plays a prioritised square-wave tone per game event, then a silent gap.
// Optional one-deep pending slot for non-preempting events, enabled by defining BEEP_PENDING_EN.
module beep_driver #(
  parameter logic [19:0] HALF_FLAP  = 20'd50_000,
  parameter logic [19:0] HALF_SCORE = 20'd25_000,
  parameter logic [19:0] HALF_CRASH = 20'd200_000,
  parameter logic [26:0] DUR_FLAP   = 27'd5_000_000,
  parameter logic [26:0] DUR_SCORE  = 27'd10_000_000,
  parameter logic [26:0] DUR_CRASH  = 27'd50_000_000,
  parameter logic [26:0] GAP_CYC    = 27'd2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_flap,
  input  logic       ev_score,
  input  logic       ev_crash,
  output logic       buzz_out,
  output logic       busy,
  output logic [1:0] cur_id
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  id_q, id_d;
  logic [1:0]  pend_q, pend_d;
  logic [19:0] half_q, half_d;
  logic [26:0] dur_q, dur_d;
  logic [26:0] gap_q, gap_d;
  logic        buzz_q, buzz_d;
  logic        busy_q, busy_d;
  logic [1:0]  cur_q, cur_d;

  logic [1:0]  ev_id;
  logic        start;
  logic [1:0]  start_id;

  // Counters are loaded with length-1 so that a zero count marks the final cycle of a phase.
  function automatic logic [19:0] half_of(input logic [1:0] id);
    case (id)
      2'd3:    half_of = HALF_CRASH - 20'd1;
      2'd2:    half_of = HALF_SCORE - 20'd1;
      default: half_of = HALF_FLAP - 20'd1;
    endcase
  endfunction

  function automatic logic [26:0] dur_of(input logic [1:0] id);
    case (id)
      2'd3:    dur_of = DUR_CRASH - 27'd1;
      2'd2:    dur_of = DUR_SCORE - 27'd1;
      default: dur_of = DUR_FLAP - 27'd1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      pend_q  <= 2'd0;
      half_q  <= 20'd0;
      dur_q   <= 27'd0;
      gap_q   <= 27'd0;
      buzz_q  <= 1'b0;
      busy_q  <= 1'b0;
      cur_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      half_q  <= half_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      buzz_q  <= buzz_d;
      busy_q  <= busy_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pend_d   = pend_q;
    half_d   = half_q;
    dur_d    = dur_q;
    gap_d    = gap_q;
    buzz_d   = buzz_q;
    start    = 1'b0;
    ev_id    = ev_crash ? 2'd3 : ev_score ? 2'd2 : ev_flap ? 2'd1 : 2'd0;
    start_id = ev_id;

    case (state_q)
      IDLE: begin
        if (ev_id != 2'd0) start = 1'b1;
      end
      PLAY: begin
        if (ev_id > id_q) begin
          start = 1'b1;
        end else begin
`ifdef BEEP_PENDING_EN
          if (ev_id != 2'd0 && (pend_q == 2'd0 || ev_id >= pend_q)) pend_d = ev_id;
`endif
          if (half_q == 20'd0) begin
            half_d = half_of(id_q);
            buzz_d = ~buzz_q;
          end else begin
            half_d = half_q - 20'd1;
          end
          // With a zero-length gap the tone hands over straight to the pending slot or IDLE.
          if (dur_q == 27'd0) begin
            if (GAP_CYC != 27'd0) begin
              state_d = GAP;
              gap_d   = GAP_CYC - 27'd1;
            end else if (pend_d != 2'd0) begin
              start    = 1'b1;
              start_id = pend_d;
              pend_d   = 2'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            dur_d = dur_q - 27'd1;
          end
        end
      end
      GAP: begin
        if (ev_id != 2'd0) begin
          start = 1'b1;
        end else if (gap_q == 27'd0) begin
          if (pend_q != 2'd0) begin
            start    = 1'b1;
            start_id = pend_q;
            pend_d   = 2'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 27'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = PLAY;
      id_d    = start_id;
      half_d  = half_of(start_id);
      dur_d   = dur_of(start_id);
      buzz_d  = 1'b1;
    end

    if (state_d != PLAY) buzz_d = 1'b0;
    busy_d = (state_d != IDLE);
    cur_d  = (state_d == PLAY) ? id_d : 2'd0;
  end

  assign buzz_out = buzz_q;
  assign busy     = busy_q;
  assign cur_id   = cur_q;

endmodule

// File: tb/tb_beep_driver.sv
// Directed self-checking bench for beep_driver using short tone/gap parameters.
// Expected waveforms are hand-derived; pending expectations follow BEEP_PENDING_EN.
module tb_beep_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ev_flap = 1'b0;
  logic       ev_score = 1'b0;
  logic       ev_crash = 1'b0;
  logic       buzz_out;
  logic       busy;
  logic [1:0] cur_id;

  int total = 0;
  int bad = 0;

  beep_driver #(
    .HALF_FLAP (20'd2),
    .HALF_SCORE(20'd3),
    .HALF_CRASH(20'd5),
    .DUR_FLAP  (27'd20),
    .DUR_SCORE (27'd20),
    .DUR_CRASH (27'd40),
    .GAP_CYC   (27'd4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ev_flap (ev_flap),
    .ev_score(ev_score),
    .ev_crash(ev_crash),
    .buzz_out(buzz_out),
    .busy    (busy),
    .cur_id  (cur_id)
  );

  always #5 clk = ~clk;

  // After step() the bench observes the cycle following the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_init got=%b want=0000", {buzz_out, busy, cur_id});
    end
    ev_crash = 1'b1;
    step();
    ev_crash = 1'b0;
    repeat (3) step();
    total++;
    if (busy !== 1'b1 || cur_id !== 2'd3) begin
      bad++;
      $display("[TB] FAIL reset_pretone busy=%b cur=%0d want busy=1 cur=3", busy, cur_id);
    end
    rst = 1'b1;
    step();
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_midtone got=%b want=0000", {buzz_out, busy, cur_id});
    end
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if ({buzz_out, busy, cur_id} !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_release i=%0d got=%b want=0000", i, {buzz_out, busy, cur_id});
      end
    end
  endtask

  task automatic test_single_flap();
    logic [3:0] exp;
    ev_flap = 1'b1;
    step();
    ev_flap = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (c <= 20)      exp = {(((c - 1) % 4) < 2) ? 1'b1 : 1'b0, 1'b1, 2'd1};
      else if (c <= 24) exp = 4'b0100;
      else              exp = 4'b0000;
      total++;
      if ({buzz_out, busy, cur_id} !== exp) begin
        bad++;
        $display("[TB] FAIL single_flap c=%0d got=%b want=%b", c, {buzz_out, busy, cur_id}, exp);
      end
      step();
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp;
    ev_flap  = 1'b1;
    ev_crash = 1'b1;
    step();
    ev_flap  = 1'b0;
    ev_crash = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      if (c <= 40)      exp = {(((c - 1) % 10) < 5) ? 1'b1 : 1'b0, 1'b1, 2'd3};
      else if (c <= 44) exp = 4'b0100;
      else              exp = 4'b0000;
      total++;
      if ({buzz_out, busy, cur_id} !== exp) begin
        bad++;
        $display("[TB] FAIL simultaneous c=%0d got=%b want=%b", c, {buzz_out, busy, cur_id}, exp);
      end
      step();
    end
  endtask

  task automatic test_preempt();
    ev_flap = 1'b1;
    step();
    ev_flap = 1'b0;
    total++;
    if (cur_id !== 2'd1 || buzz_out !== 1'b1) begin
      bad++;
      $display("[TB] FAIL preempt_flap cur=%0d buzz=%b want cur=1 buzz=1", cur_id, buzz_out);
    end
    repeat (4) step();
    ev_crash = 1'b1;
    step();
    ev_crash = 1'b0;
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL preempt_start got=%b want=1111", {buzz_out, busy, cur_id});
    end
    repeat (39) step();
    total++;
    if (busy !== 1'b1 || cur_id !== 2'd3) begin
      bad++;
      $display("[TB] FAIL preempt_last busy=%b cur=%0d want busy=1 cur=3", busy, cur_id);
    end
    step();
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL preempt_gap got=%b want=0100", {buzz_out, busy, cur_id});
    end
    repeat (4) step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL preempt_idle busy=%b want=0", busy);
    end
  endtask

  task automatic test_pending();
    ev_score = 1'b1;
    step();
    ev_score = 1'b0;
    repeat (4) step();
    ev_flap = 1'b1;
    step();
    ev_flap = 1'b0;
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0110) begin
      bad++;
      $display("[TB] FAIL pending_noprempt got=%b want=0110", {buzz_out, busy, cur_id});
    end
    repeat (14) step();
    total++;
    if (cur_id !== 2'd2) begin
      bad++;
      $display("[TB] FAIL pending_score_end cur=%0d want=2", cur_id);
    end
    step();
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL pending_gap got=%b want=0100", {buzz_out, busy, cur_id});
    end
    repeat (4) step();
`ifdef BEEP_PENDING_EN
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b1101) begin
      bad++;
      $display("[TB] FAIL pending_flap_start got=%b want=1101", {buzz_out, busy, cur_id});
    end
    repeat (19) step();
    total++;
    if (busy !== 1'b1 || cur_id !== 2'd1) begin
      bad++;
      $display("[TB] FAIL pending_flap_end busy=%b cur=%0d want busy=1 cur=1", busy, cur_id);
    end
    step();
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL pending_flap_gap got=%b want=0100", {buzz_out, busy, cur_id});
    end
    repeat (4) step();
`endif
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL pending_idle got=%b want=0000", {buzz_out, busy, cur_id});
    end
  endtask

  task automatic test_gap_boundary();
    ev_flap = 1'b1;
    step();
    ev_flap = 1'b0;
    repeat (23) step();
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL gap_last got=%b want=0100", {buzz_out, busy, cur_id});
    end
    ev_score = 1'b1;
    step();
    ev_score = 1'b0;
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b1110) begin
      bad++;
      $display("[TB] FAIL gap_preempt got=%b want=1110", {buzz_out, busy, cur_id});
    end
    repeat (3) step();
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0110) begin
      bad++;
      $display("[TB] FAIL gap_preempt_half got=%b want=0110", {buzz_out, busy, cur_id});
    end
    repeat (21) step();
    total++;
    if ({buzz_out, busy, cur_id} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL gap_preempt_idle got=%b want=0000", {buzz_out, busy, cur_id});
    end
  endtask

  initial begin
    test_reset();
    repeat (3) step();
    test_single_flap();
    repeat (3) step();
    test_simultaneous();
    repeat (3) step();
    test_preempt();
    repeat (3) step();
    test_pending();
    repeat (3) step();
    test_gap_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beep_driver.md
# beep_driver

Drives the on-board piezo buzzer from one-cycle game event pulses (flap, score, crash) produced by the debounced-button and game-logic blocks. Each event plays a fixed-pitch square-wave tone for a fixed duration, then enforces a silent gap. Crash outranks score, and score outranks flap. The block sits between game control and the buzzer pin, which it drives directly.

## Interface
- HALF_FLAP, 20'd50_000, flap tone half-period in clk cycles (1 kHz at 100 MHz); must be ≥1
- HALF_SCORE, 20'd25_000, score tone half-period (2 kHz); must be ≥1
- HALF_CRASH, 20'd200_000, crash tone half-period (250 Hz); must be ≥1
- DUR_FLAP, 27'd5_000_000, flap tone length in cycles (50 ms); must be ≥1
- DUR_SCORE, 27'd10_000_000, score tone length (100 ms); must be ≥1
- DUR_CRASH, 27'd50_000_000, crash tone length (500 ms); must be ≥1
- GAP_CYC, 27'd2_000_000, silence after every tone (20 ms); 0 allowed
- clk  input  1  100 MHz system clock
- rst  input  1  reset; one clock, synchronous, active-high
- ev_flap  input  1  one-cycle flap event pulse
- ev_score  input  1  one-cycle score event pulse
- ev_crash  input  1  one-cycle crash event pulse
- buzz_out  output  1  square wave to buzzer, registered
- busy  output  1  high in PLAY or GAP, registered
- cur_id  output  2  tone currently playing: 0 none, 1 flap, 2 score, 3 crash; registered, 0 in GAP

## Operation
- Event ID equals its priority: crash 3 > score 2 > flap 1. If several events arrive in the same cycle, only the highest is considered. Lower simultaneous events are discarded.
- States:
  - IDLE: buzz_out=0, busy=0, cur_id=0. An event moves the block to PLAY with that ID.
  - PLAY: toggle buzz_out every HALF_x cycles for DUR_x cycles, then go to GAP. If GAP_CYC=0, skip GAP and go to the next state described under GAP.
  - GAP: buzz_out=0, cur_id=0, busy=1, for GAP_CYC cycles. Then go to PLAY with the pending ID if one is held (clearing the slot), otherwise to IDLE.
- Preemption:
  - During PLAY, an event with ID > cur_id restarts PLAY with the new ID in the next cycle. The duration and half-period counters reload, and buzz_out restarts high.
  - During GAP, any event preempts and starts PLAY in the next cycle.
  - The pending slot is unaffected by preemption.
- Non-preempting event during PLAY (ID ≤ cur_id) goes to the pending slot. The slot accepts it if the slot is empty or the new ID ≥ the held ID.
- Counters:
  - Half-period counter: 20-bit down-counter.
  - Duration and gap counters: 27-bit down-counters.
  - No wrap: the counters reload on every state entry.
- Reset has priority over all inputs. Reset mid-tone silences buzz_out on the next edge and clears all state, counters and the pending slot.

## Timing
- Reset values: buzz_out=0, busy=0, cur_id=0, state IDLE, pending empty.
- Start of PLAY: an event sampled high at edge N gives buzz_out=1, busy=1 and cur_id=ID after edge N. Latency is 1 cycle.
- During PLAY, buzz_out holds each level for exactly HALF_x cycles. The first high phase covers cycles N+1..N+HALF_x.
- End of PLAY: PLAY spans exactly DUR_x cycles. The last PLAY cycle is N+DUR_x. buzz_out=0 and cur_id=0 from cycle N+DUR_x+1.
- GAP: spans exactly GAP_CYC cycles.
- Start of a pending tone: a pending tone begins at cycle N+DUR_x+GAP_CYC+1 with buzz_out=1.
- End of busy: busy falls in that same cycle if nothing is pending.
- Boundary events:
  - An event arriving in the last PLAY cycle is handled under PLAY rules.
  - An event arriving in the last GAP cycle preempts.
  - When pending exists at that point, the preempting event wins and pending remains held.

## Configuration
- BEEP_PENDING_EN defined: the one-deep pending slot is compiled in, as described above.
- BEEP_PENDING_EN undefined:
  - No pending slot.
  - Non-preempting events during PLAY are dropped.
  - GAP always exits to IDLE.
  - Preemption is unchanged.

## Test plan
Bench parameters: HALF_FLAP=2, HALF_SCORE=3, HALF_CRASH=5, DUR_FLAP=20, DUR_SCORE=20, DUR_CRASH=40, GAP_CYC=4.

- Reset: assert rst for 3 cycles, including mid-tone → buzz_out=0, busy=0 and cur_id=0 on the edge after rst is sampled; no tone after release until an event.
- Single flap: pulse ev_flap at cycle 10 → cycles 11..30 show buzz_out in the pattern 1,1,0,0 repeated; cur_id=1; cycles 31..34 show buzz_out=0, busy=1; busy=0 at cycle 35.
- Simultaneous events: ev_flap and ev_crash pulsed in the same cycle → cur_id=3 with a 5-cycle half-period; no flap tone is ever played afterward.
- Preemption: ev_flap at cycle 10, then ev_crash at cycle 15 → cur_id=3 and buzz_out=1 at cycle 16; crash PLAY ends after cycle 55.
- Pending (macro on): ev_score at cycle 10, then ev_flap at cycle 15 → score plays cycles 11..30, gap 31..34, flap plays 35..54 with cur_id=1.
- Pending (macro off): same stimulus → flap is dropped; busy=0 at cycle 35.
